// File: rtl/mr_scoreboard_if.sv
// Decode, writeback and status signals of the register file / write scoreboard.
// master = decode-side driver, slave = mr_scoreboard.
interface mr_scoreboard_if #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int WB_PORTS = 2
);
   localparam int AW = $clog2(NREGS);

   logic [AW-1:0]            rs1;
   logic [AW-1:0]            rs2;
   logic [AW-1:0]            rsd;
   logic                     use_rs1;
   logic                     use_rs2;
   logic                     use_rsd;
   logic                     is_jmp;
   logic                     issue_fire;
   logic [XLEN-1:0]          rs1_data;
   logic [XLEN-1:0]          rs2_data;
   logic                     hazard;
   logic [WB_PORTS-1:0]      wb_valid;
   logic [WB_PORTS*AW-1:0]   wb_reg;
   logic [WB_PORTS*XLEN-1:0] wb_val;
   logic                     jmp_done;
   logic                     flush;
   logic                     pending_any;
   logic                     err;

   modport master (
      output rs1, rs2, rsd, use_rs1, use_rs2, use_rsd, is_jmp, issue_fire,
      output wb_valid, wb_reg, wb_val, jmp_done, flush,
      input  rs1_data, rs2_data, hazard, pending_any, err
   );

   modport slave (
      input  rs1, rs2, rsd, use_rs1, use_rs2, use_rsd, is_jmp, issue_fire,
      input  wb_valid, wb_reg, wb_val, jmp_done, flush,
      output rs1_data, rs2_data, hazard, pending_any, err
   );
endinterface

// File: rtl/mr_scoreboard.sv
// Register file with per-register pending-write counters, jump tracking,
// optional same-cycle writeback bypass, flush and a sticky protocol-error flag.
module mr_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int CNT_BITS = 2,
   parameter int WB_PORTS = 2,
   parameter int MAX_JMP  = 1,
   parameter int BYPASS   = 1
) (
   input logic           clk,
   input logic           rst,
   mr_scoreboard_if.slave bus
);
   localparam int AW   = $clog2(NREGS);
   localparam int JW   = $clog2(MAX_JMP + 1);
   localparam int CMAX = (1 << CNT_BITS) - 1;

   logic [XLEN-1:0]     regs   [NREGS];
   logic [CNT_BITS-1:0] pend   [NREGS];
   logic [CNT_BITS-1:0] pend_n [NREGS];
   logic [CNT_BITS-1:0] orph   [NREGS];
   logic [CNT_BITS-1:0] orph_n [NREGS];
   logic [JW-1:0]       jmp_cnt, jmp_n;
   logic                err_q, err_set, any_q, any_n;
   logic [XLEN:0]       rd1, rd2;
   logic [AW-1:0]       wb_dst  [WB_PORTS];
   logic [XLEN-1:0]     wb_data [WB_PORTS];
   logic                haz;

   always_comb begin
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
         wb_dst[p]  = bus.wb_reg[p*AW +: AW];
         wb_data[p] = bus.wb_val[p*XLEN +: XLEN];
      end
   end

   // Returns {bypass_hit, data}; descending scan so the lowest-indexed port wins.
   function automatic logic [XLEN:0] read_sel(input logic [AW-1:0] sel);
      logic [XLEN:0] res;
      res = {1'b0, regs[sel]};
      if (BYPASS != 0 && pend[sel] == CNT_BITS'(1)) begin
         for (int unsigned p = WB_PORTS; p > 0; p--) begin
            if (bus.wb_valid[p-1] && wb_dst[p-1] == sel)
               res = {1'b1, wb_data[p-1]};
         end
      end
      if (sel == '0)
         res = '0;
      return res;
   endfunction

   always_comb begin
      rd1 = read_sel(bus.rs1);
      rd2 = read_sel(bus.rs2);
      haz = (bus.use_rs1 && bus.rs1 != '0 && pend[bus.rs1] != '0 && !rd1[XLEN])
         || (bus.use_rs2 && bus.rs2 != '0 && pend[bus.rs2] != '0 && !rd2[XLEN])
         || (jmp_cnt == JW'(MAX_JMP))
         || (bus.use_rsd && bus.rsd != '0 && pend[bus.rsd] == CNT_BITS'(CMAX));
   end

   assign bus.rs1_data    = rd1[XLEN-1:0];
   assign bus.rs2_data    = rd2[XLEN-1:0];
   assign bus.hazard      = haz;
   assign bus.pending_any = any_q;
   assign bus.err         = err_q;

   // Writebacks still in flight when a flush drops their counts are remembered
   // as orphans, so their later arrival is absorbed without flagging underflow.
   always_comb begin
      err_set   = bus.issue_fire && haz;
      pend_n[0] = '0;
      orph_n[0] = '0;
      for (int unsigned r = 1; r < NREGS; r++) begin
         int n;
         int o;
         int dec;
         dec = 0;
         for (int unsigned p = 0; p < WB_PORTS; p++)
            if (bus.wb_valid[p] && wb_dst[p] == AW'(r))
               dec = dec + 1;
         n = int'(pend[r]) - dec;
         if (bus.issue_fire && !bus.flush && bus.use_rsd && bus.rsd == AW'(r))
            n = n + 1;
         o = int'(orph[r]);
         if (n < 0) begin
            if (-n > o) begin
               err_set = 1'b1;
               o = 0;
            end else begin
               o = o + n;
            end
            n = 0;
         end
         if (n > CMAX)
            n = CMAX;
         if (bus.flush) begin
            o = (o + n > CMAX) ? CMAX : o + n;
            n = 0;
         end
         pend_n[r] = CNT_BITS'(n);
         orph_n[r] = CNT_BITS'(o);
      end

      for (int unsigned p = 0; p < WB_PORTS; p++)
         for (int unsigned q = p + 1; q < WB_PORTS; q++)
            if (bus.wb_valid[p] && bus.wb_valid[q] && wb_dst[p] == wb_dst[q] && wb_dst[p] != '0)
               err_set = 1'b1;

      jmp_n = jmp_cnt;
      if (bus.jmp_done && jmp_cnt == '0) begin
         err_set = 1'b1;
         jmp_n   = '0;
      end else if (bus.issue_fire && bus.is_jmp && !bus.jmp_done) begin
         if (jmp_cnt != JW'(MAX_JMP))
            jmp_n = jmp_cnt + JW'(1);
      end else if (bus.jmp_done && !(bus.issue_fire && bus.is_jmp)) begin
         jmp_n = jmp_cnt - JW'(1);
      end
      if (bus.flush)
         jmp_n = '0;

      any_n = (jmp_n != '0);
      for (int unsigned r = 1; r < NREGS; r++)
         if (pend_n[r] != '0)
            any_n = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
            pend[r] <= '0;
            orph[r] <= '0;
         end
         jmp_cnt <= '0;
         err_q   <= 1'b0;
         any_q   <= 1'b0;
      end else begin
         for (int unsigned p = WB_PORTS; p > 0; p--)
            if (bus.wb_valid[p-1] && wb_dst[p-1] != '0)
               regs[wb_dst[p-1]] <= wb_data[p-1];
         for (int unsigned r = 0; r < NREGS; r++) begin
            pend[r] <= pend_n[r];
            orph[r] <= orph_n[r];
         end
         jmp_cnt <= jmp_n;
         err_q   <= err_q | err_set;
         any_q   <= any_n;
      end
   end
endmodule

// File: tb/tb_mr_scoreboard.sv
// Directed bench for mr_scoreboard: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_mr_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      int          cyc;
      string       name;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];

   mr_scoreboard_if #(.XLEN(32), .NREGS(32), .WB_PORTS(2)) bus ();

   mr_scoreboard #(
      .XLEN(32), .NREGS(32), .CNT_BITS(2), .WB_PORTS(2), .MAX_JMP(1), .BYPASS(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pick(input int sel);
      case (sel)
         0:       pick = bus.rs1_data;
         1:       pick = bus.rs2_data;
         2:       pick = {31'd0, bus.hazard};
         3:       pick = {31'd0, bus.pending_any};
         default: pick = {31'd0, bus.err};
      endcase
   endfunction

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] act;
         e   = q.pop_front();
         act = pick(e.sel);
         total++;
         if (act !== e.val) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %h want %h", e.name, e.cyc, act, e.val);
         end
      end
   end

   task automatic chk(input string nm, input int sel, input logic [31:0] v);
      q.push_back('{cyc, nm, sel, v});
   endtask

   task automatic idle();
      bus.rs1 = '0; bus.rs2 = '0; bus.rsd = '0;
      bus.use_rs1 = 1'b0; bus.use_rs2 = 1'b0; bus.use_rsd = 1'b0;
      bus.is_jmp = 1'b0; bus.issue_fire = 1'b0;
      bus.wb_valid = '0; bus.wb_reg = '0; bus.wb_val = '0;
      bus.jmp_done = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic issue_rd(input logic [4:0] r);
      bus.use_rsd = 1'b1; bus.rsd = r; bus.issue_fire = 1'b1;
   endtask

   task automatic wb(input int p, input logic [4:0] r, input logic [31:0] v);
      bus.wb_valid[p]        = 1'b1;
      bus.wb_reg[p*5 +: 5]   = r;
      bus.wb_val[p*32 +: 32] = v;
   endtask

   task automatic read1(input logic [4:0] r);
      bus.use_rs1 = 1'b1; bus.rs1 = r;
   endtask

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      read1(5); bus.use_rs2 = 1'b1; bus.rs2 = 0;
      chk("rst_rs1", 0, 0); chk("rst_rs2", 1, 0); chk("rst_haz", 2, 0);
      chk("rst_err", 4, 0); chk("rst_pend", 3, 0);
      step();

      // RAW on x3, resolved by bypass
      issue_rd(3); chk("x3_issue_haz", 2, 0);
      step();
      read1(3); chk("x3_raw_haz", 2, 1); chk("x3_pend_any", 3, 1);
      step();
      read1(3); wb(0, 3, 32'hDEADBEEF);
      chk("x3_byp_haz", 2, 0); chk("x3_byp_data", 0, 32'hDEADBEEF);
      step();
      read1(3); chk("x3_after_haz", 2, 0); chk("x3_after_data", 0, 32'hDEADBEEF);
      chk("x3_after_pend", 3, 0);
      step();

      // saturating pending count on x7
      for (int i = 0; i < 3; i++) begin
         issue_rd(7); chk("x7_fill_haz", 2, 0);
         step();
      end
      bus.use_rsd = 1'b1; bus.rsd = 7; chk("x7_full_haz", 2, 1); chk("x7_err0", 4, 0);
      step();
      issue_rd(7); wb(0, 7, 32'h77); chk("x7_net_haz", 2, 1);
      step();
      bus.use_rsd = 1'b1; bus.rsd = 7; read1(7);
      chk("x7_still_full", 2, 1); chk("x7_fire_haz_err", 4, 1); chk("x7_data", 0, 32'h77);
      step();
      do_reset();

      // two ports writing x9 in one cycle
      issue_rd(9); step();
      issue_rd(9); step();
      read1(9); wb(0, 9, 32'h11); wb(1, 9, 32'h22);
      chk("x9_nobyp_haz", 2, 1); chk("x9_nobyp_data", 0, 0);
      step();
      read1(9); chk("x9_data", 0, 32'h11); chk("x9_haz", 2, 0);
      chk("x9_err", 4, 1); chk("x9_pend", 3, 0);
      step();
      do_reset();

      // jump tracking
      bus.issue_fire = 1'b1; bus.is_jmp = 1'b1; chk("j_issue_haz", 2, 0);
      step();
      chk("j_haz", 2, 1); chk("j_pend", 3, 1);
      step();
      bus.issue_fire = 1'b1; bus.is_jmp = 1'b1; bus.jmp_done = 1'b1; chk("j_swap_haz", 2, 1);
      step();
      chk("j_hold_haz", 2, 1); chk("j_fire_haz_err", 4, 1);
      bus.jmp_done = 1'b1;
      step();
      chk("j_clear_haz", 2, 0); chk("j_clear_pend", 3, 0);
      step();
      do_reset();
      bus.jmp_done = 1'b1;
      step();
      chk("j_under_err", 4, 1); chk("j_under_haz", 2, 0); chk("j_under_pend", 3, 0);
      step();
      do_reset();

      // flush with pending x4 and a jump in flight
      issue_rd(4); step();
      issue_rd(4); step();
      bus.issue_fire = 1'b1; bus.is_jmp = 1'b1; step();
      chk("f_pre_haz", 2, 1); chk("f_pre_pend", 3, 1);
      step();
      bus.flush = 1'b1;
      step();
      read1(4); chk("f_haz", 2, 0); chk("f_pend", 3, 0); chk("f_err", 4, 0);
      step();
      wb(0, 4, 32'h5);
      step();
      read1(4); chk("f_late_data", 0, 32'h5); chk("f_late_err", 4, 0);
      step();

      // asynchronous reset mid-run
      bus.jmp_done = 1'b1; step();
      issue_rd(12); step();
      bus.issue_fire = 1'b1; bus.is_jmp = 1'b1; step();
      read1(4);
      chk("a_pre_data", 0, 32'h5); chk("a_pre_haz", 2, 1);
      chk("a_pre_pend", 3, 1); chk("a_pre_err", 4, 1);
      step();
      read1(4); rst = 1'b1;
      chk("a_rs1", 0, 0); chk("a_haz", 2, 0); chk("a_pend", 3, 0); chk("a_err", 4, 0);
      step();
      rst = 1'b0;

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain: got %0d pending checks want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mr_scoreboard.md
Name: mr_scoreboard

Overview:
- Parametrised register file plus write-scoreboard for the in-order RV32I pipeline; the decode stage instantiates it.
- Generalises the hazard tracking into one block:
  - configurable register count;
  - configurable per-register pending-write depth;
  - multiple writeback ports;
  - multiple outstanding jumps;
  - optional same-cycle writeback bypass;
  - flush;
  - sticky protocol-error flag.
- Decode presents operand selects, gets data plus a combinational hazard, and pulses issue_fire when the instruction actually leaves decode.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural registers; x0 hardwired zero.
- CNT_BITS, 2, width of each per-register pending-write counter; max count 2^CNT_BITS-1.
- WB_PORTS, 2, number of writeback ports.
- MAX_JMP, 1, maximum unresolved jumps/branches in flight.
- BYPASS, 1, 1 enables forwarding of same-cycle writeback data to reads.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rs1  in  clog2(NREGS)  source 1 select.
- rs2  in  clog2(NREGS)  source 2 select.
- rsd  in  clog2(NREGS)  destination select.
- use_rs1  in  1  instruction reads rs1.
- use_rs2  in  1  instruction reads rs2.
- use_rsd  in  1  instruction writes rsd.
- is_jmp  in  1  instruction is a jump/branch needing resolution.
- issue_fire  in  1  instruction issues this cycle.
- rs1_data  out  XLEN  operand 1 (combinational).
- rs2_data  out  XLEN  operand 2 (combinational).
- hazard  out  1  instruction must stall (combinational).
- wb_valid  in  WB_PORTS  per-port writeback strobe.
- wb_reg  in  WB_PORTS*clog2(NREGS)  per-port destination; port p at slice p.
- wb_val  in  WB_PORTS*XLEN  per-port data.
- jmp_done  in  1  one outstanding jump resolved.
- flush  in  1  synchronous clear of all pending state.
- pending_any  out  1  registered; some register count or jump count nonzero.
- err  out  1  registered sticky protocol-error flag.

Behaviour:
- Reset (async, rst=1):
  - all registers 0, all counters 0, jmp count 0;
  - err=0, pending_any=0;
  - issue_fire and wb inputs ignored while rst high.
- Reads, combinational:
  - select 0 returns 0.
  - If BYPASS=1, pend(r)==1 and some wb port this cycle has wb_valid & wb_reg==r: return that port's wb_val (lowest-indexed matching port wins).
  - Otherwise return regfile[r].
- hazard is the OR of:
  - use_rs1 & rs1!=0 & pend(rs1)!=0 & !bypass_hit1;
  - same term for rs2;
  - jmp_cnt==MAX_JMP;
  - use_rsd & rsd!=0 & pend(rsd)==2^CNT_BITS-1.
  - No dependence on issue_fire.
- Counter update per register r != 0, each cycle:
  - next = pend + inc − dec.
  - inc = issue_fire & use_rsd & rsd==r.
  - dec = number of ports with wb_valid & wb_reg==r.
  - Simultaneous inc and dec on the same register nets out.
  - Underflow: clamp to 0, set err.
  - issue_fire while hazard=1: err set; counters still update, overflow clamps at max.
- Regfile write:
  - every wb_valid port with wb_reg!=0 writes wb_val at the clock edge.
  - Two ports writing the same register in one cycle: lowest-indexed port's value lands, err set.
  - wb_reg==0 is ignored entirely (no counter change, no error).
- Jump counter, width clog2(MAX_JMP+1):
  - +1 on issue_fire & is_jmp; −1 on jmp_done; both in one cycle holds.
  - jmp_done at 0: err set, stays 0.
- flush (synchronous):
  - next cycle all pend=0 and jmp_cnt=0;
  - same-cycle wb writes still update the regfile;
  - same-cycle issue_fire does not count;
  - a later wb to a register with pend 0 writes data, no err.
- pending_any is registered from next-state: OR of all counters and jmp_cnt.
- err is cleared only by rst.

Test Plan:
- Reset, read rs1=5, rs2=0 → rs1_data=0, rs2_data=0, hazard=0, err=0, pending_any=0.
- Issue rsd=3 with use_rsd, next cycle read use_rs1 rs1=3 → hazard=1. wb port0 reg3 val 0xDEADBEEF that cycle with BYPASS=1 → hazard=0, rs1_data=0xDEADBEEF. Next cycle pend(3)=0 and regfile[3]=0xDEADBEEF.
- Issue rsd=7 three times (CNT_BITS=2) → pend=3. Fourth attempt use_rsd rsd=7 → hazard=1. Issue plus wb reg7 in the same cycle → pend stays 3.
- Ports 0 and 1 both write reg9 (0x11, 0x22) with pend(9)=2 → regfile[9]=0x11, pend(9)=0, err=1.
- MAX_JMP=1: issue is_jmp → hazard=1 next cycle. jmp_done plus new is_jmp issue in the same cycle → jmp_cnt stays 1. jmp_done at 0 → err=1.
- pend(4)=2 and jmp_cnt=1, assert flush → next cycle pending_any=0, hazard=0. Later wb reg4 0x5 → regfile[4]=5, err unchanged. Assert rst mid-run → all outputs 0 immediately, without waiting for a clock edge.
